// File: rtl/halfword_pkg.sv
// Shared widths and FSM state type for the halfword serializer.
package halfword_pkg;

  localparam int HW_WIDTH     = 16;
  localparam int HW_FRAME_LEN = 16;
  localparam int HW_CNT_W     = $clog2(HW_FRAME_LEN);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/halfword_serializer.sv
// Loads a 16-halfword parallel frame and emits it in15 first down to in0 over a valid/ready stream.
// Optional out_last port is enabled by defining HALFWORD_SERIALIZER_LAST_EN.
//
// state | meaning
// IDLE  | no frame held; accepting a new frame, out_valid low
// SEND  | frame held; presenting buffer[cnt], can reload on the final beat
module halfword_serializer
  import halfword_pkg::*;
#(
  parameter int LENGTH = HW_FRAME_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [HW_WIDTH-1:0] in0,
  input  logic [HW_WIDTH-1:0] in1,
  input  logic [HW_WIDTH-1:0] in2,
  input  logic [HW_WIDTH-1:0] in3,
  input  logic [HW_WIDTH-1:0] in4,
  input  logic [HW_WIDTH-1:0] in5,
  input  logic [HW_WIDTH-1:0] in6,
  input  logic [HW_WIDTH-1:0] in7,
  input  logic [HW_WIDTH-1:0] in8,
  input  logic [HW_WIDTH-1:0] in9,
  input  logic [HW_WIDTH-1:0] in10,
  input  logic [HW_WIDTH-1:0] in11,
  input  logic [HW_WIDTH-1:0] in12,
  input  logic [HW_WIDTH-1:0] in13,
  input  logic [HW_WIDTH-1:0] in14,
  input  logic [HW_WIDTH-1:0] in15,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [HW_WIDTH-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef HALFWORD_SERIALIZER_LAST_EN
  output logic                out_last,
`endif
  output logic                busy
);

  ser_state_t          state;
  ser_state_t          state_next;
  logic [HW_WIDTH-1:0] buffer [HW_FRAME_LEN];
  logic [HW_WIDTH-1:0] frame  [HW_FRAME_LEN];
  logic [HW_CNT_W-1:0] cnt;
  logic                load;
  logic                beat;
  logic                last_idx;

  assign frame[0]  = in0;
  assign frame[1]  = in1;
  assign frame[2]  = in2;
  assign frame[3]  = in3;
  assign frame[4]  = in4;
  assign frame[5]  = in5;
  assign frame[6]  = in6;
  assign frame[7]  = in7;
  assign frame[8]  = in8;
  assign frame[9]  = in9;
  assign frame[10] = in10;
  assign frame[11] = in11;
  assign frame[12] = in12;
  assign frame[13] = in13;
  assign frame[14] = in14;
  assign frame[15] = in15;

  assign last_idx  = (cnt == '0);
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_data  = (state == SEND) ? buffer[cnt] : '0;
  assign load      = in_valid && in_ready;
  assign beat      = out_valid && out_ready;

`ifdef HALFWORD_SERIALIZER_LAST_EN
  assign out_last  = out_valid && last_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // in_ready is gated by rst_n so it reads low throughout reset
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (load) state_next = SEND;
      end
      SEND: begin
        in_ready = last_idx && out_ready;
        if (beat && last_idx && !load) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < HW_FRAME_LEN; i++) buffer[i] <= '0;
    end else if (load) begin
      cnt <= HW_CNT_W'(LENGTH - 1);
      for (int i = 0; i < HW_FRAME_LEN; i++) buffer[i] <= frame[i];
    end else if (beat && !last_idx) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_halfword_serializer.sv
// Self-checking bench for halfword_serializer: directed frames plus random traffic against a queue model.
// Covers the HALFWORD_SERIALIZER_LAST_EN build when that macro is defined.
module tb_halfword_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din [16];
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef HALFWORD_SERIALIZER_LAST_EN
  logic        out_last;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] q[$];          // halfwords still owed downstream, in emission order
  logic [15:0] chain [16];    // downstream shift chain: out0 takes out_data on each beat
  int          beats_seen;

  always #5 clk = ~clk;

  halfword_serializer dut (
    .clk(clk), .rst_n(rst_n),
    .in0(din[0]),   .in1(din[1]),   .in2(din[2]),   .in3(din[3]),
    .in4(din[4]),   .in5(din[5]),   .in6(din[6]),   .in7(din[7]),
    .in8(din[8]),   .in9(din[9]),   .in10(din[10]), .in11(din[11]),
    .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef HALFWORD_SERIALIZER_LAST_EN
    .out_last(out_last),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model, then advance one clock and update the model.
  task automatic cycle();
    logic        ev, er, beat, load;
    logic [15:0] ed;
    #1;
    ev = (q.size() != 0);
    ed = ev ? q[0] : 16'h0;
    er = rst_n && ((q.size() == 0) || (q.size() == 1 && out_ready));
    chk("out_valid", out_valid, ev);
    chk("out_data", out_data, ed);
    chk("in_ready", in_ready, er);
    chk("busy", busy, ev);
`ifdef HALFWORD_SERIALIZER_LAST_EN
    chk("out_last", out_last, ev && q.size() == 1);
`endif
    beat = ev && out_ready;
    load = in_valid && er;
    @(posedge clk);
    if (beat) begin
      void'(q.pop_front());
      for (int k = 15; k > 0; k--) chain[k] = chain[k-1];
      chain[0] = ed;
      beats_seen++;
    end
    if (load) for (int k = 15; k >= 0; k--) q.push_back(din[k]);
    @(negedge clk);
  endtask

  task automatic set_frame(input logic [15:0] base);
    for (int k = 0; k < 16; k++) din[k] = base + 16'(k);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    beats_seen = 0;
    for (int k = 0; k < 16; k++) begin din[k] = 16'h0; chain[k] = 16'h0; end
    @(negedge clk);

    // reset state: everything low, including in_ready
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // single frame at full rate
    set_frame(16'h1000); in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; set_frame(16'h5555);
    for (int i = 0; i < 16; i++) cycle();
    chk("frame1_done_valid", out_valid, 1'b0);
    chk("frame1_done_ready", in_ready, 1'b1);

    // out_ready toggling: 16 beats over 31 cycles
    set_frame(16'h2000); in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    beats_seen = 0;
    for (int i = 0; i < 31; i++) begin
      out_ready = (i % 2 == 0);
      cycle();
    end
    chk("toggle_beats", beats_seen, 16);
    out_ready = 1'b1;
    cycle();
    chk("toggle_done", out_valid, 1'b0);

    // back-to-back frames A then B, no bubble
    set_frame(16'hA000); in_valid = 1'b1;
    cycle();
    set_frame(16'hB000);
    for (int i = 0; i < 15; i++) cycle();
    chk("b2b_last_a", out_data, 16'hA000);
    chk("b2b_ready_on_last", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("b2b_first_b", out_data, 16'hB00F);
    chk("b2b_no_bubble", out_valid, 1'b1);
    for (int i = 0; i < 16; i++) cycle();

    // reset after beat 5 abandons the frame
    set_frame(16'hC000); in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b0);
    chk("rst_mid_data", out_data, 16'h0);
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // shift chain with in_k = k ends with out_k = k
    for (int k = 0; k < 16; k++) din[k] = 16'(k);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) din[k] = 16'hFFFF;
    for (int i = 0; i < 16; i++) cycle();
    for (int k = 0; k < 16; k++) chk($sformatf("chain_out%0d", k), chain[k], k);

`ifdef HALFWORD_SERIALIZER_LAST_EN
    // stall on the final beat keeps out_last high with in0
    set_frame(16'hD000); in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("last_stall", out_last, 1'b1);
      chk("last_stall_data", out_data, 16'hD000);
    end
    out_ready = 1'b1;
    cycle();
`endif

    // random traffic; inputs scrambled every cycle so only load cycles matter
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 16; k++) din[k] = 16'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/halfword_serializer.md
HALFWORD_SERIALIZER -- requirements
Module: halfword_serializer

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst_n, which is asynchronous and active-low.
REQ-002 Parameter LENGTH SHALL default to 16 and SHALL set the number of halfwords per frame; only the value 16 is supported.
REQ-003 Port clk SHALL be input, 1 bit: the rising-edge clock.
REQ-004 Port rst_n SHALL be input, 1 bit: the asynchronous active-low reset.
REQ-005 Ports in0..in15 SHALL be inputs, 16 bits each: the parallel frame to be loaded.
REQ-006 Port in_valid SHALL be input, 1 bit: the frame on in0..in15 is valid.
REQ-007 Port in_ready SHALL be output, 1 bit: the block accepts a frame this cycle.
REQ-008 Port out_data SHALL be output, 16 bits: the halfword currently presented.
REQ-009 Port out_valid SHALL be output, 1 bit: out_data is valid.
REQ-010 Port out_ready SHALL be input, 1 bit: the downstream consumer accepts out_data.
REQ-011 Port busy SHALL be output, 1 bit: high whenever a frame is held (state SEND).

Function
REQ-012 A load SHALL occur on a rising edge where in_valid and in_ready are both high; a beat SHALL occur on a rising edge where out_valid and out_ready are both high.
REQ-013 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 On a load, the block SHALL capture in0..in15 into an internal buffer, set index cnt to LENGTH-1, and enter SEND.
REQ-016 In SEND, out_valid SHALL be 1 and out_data SHALL equal buffer[cnt].
REQ-017 Emission order SHALL be in15 first down to in0 last, so a downstream halfword shift chain enabled on each beat ends with out0..out15 equal to in0..in15.
REQ-018 On each beat with cnt>0, cnt SHALL decrement by 1.
REQ-019 On a beat with cnt==0, the FSM SHALL return to IDLE unless a load occurs in the same cycle.
REQ-020 Latency SHALL be one cycle from load to the first out_valid; a frame SHALL take 16 beats at full rate.
REQ-021 While out_valid is high and out_ready is low, out_data and cnt SHALL hold stable.
REQ-022 In SEND, in_ready SHALL equal (cnt==0 and out_ready). This output is combinational from out_ready.
REQ-023 Frames SHALL therefore stream back-to-back with no bubble.
REQ-024 A load and the final beat SHALL be allowed to coincide: the new frame is captured, cnt is set to 15, and the FSM stays in SEND.
REQ-025 in0..in15 SHALL be ignored except on a load cycle.
REQ-026 out_data SHALL be 0 in IDLE.

Reset
REQ-027 While rst_n is low, the block SHALL force state IDLE, buffer 0, cnt 0, out_data 0, out_valid 0, busy 0, and in_ready 0.
REQ-028 Assertion of rst_n mid-frame SHALL immediately abandon the frame; no remaining halfwords are emitted after release.
REQ-029 in_ready SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-030 The macro HALFWORD_SERIALIZER_LAST_EN SHALL control the output port out_last, 1 bit.
REQ-031 When the macro is defined, out_last SHALL be high exactly when out_valid is high and cnt==0, and low at reset.
REQ-032 When the macro is undefined, the out_last port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-033 The shared package halfword_pkg SHALL hold HW_WIDTH=16, HW_FRAME_LEN=16, and the state enum ser_state_t {IDLE, SEND}.
REQ-034 The block SHALL be a single module with no sub-modules; the 16x16 buffer and the 4-bit cnt are local.

Verification
REQ-035 Reset then load in_k=16'h1000+k with out_ready=1 SHALL produce out_data 16'h100F down to 16'h1000 on 16 consecutive cycles, then out_valid=0 and in_ready=1.
REQ-036 Toggling out_ready 1/0 every cycle during a frame SHALL keep out_data stable on stall cycles, with the frame completing in 31 cycles and no value lost or duplicated.
REQ-037 Two frames (A: 16'hA000+k, B: 16'hB000+k) offered back-to-back SHALL load B on A's final beat (16'hA000), with 16'hB00F following on the next cycle with no bubble.
REQ-038 Driving rst_n low after beat 5 of a frame SHALL drop out_valid immediately; after release, in_ready=1 and no stale data is emitted.
REQ-039 Chaining into a halfword shift chain (ena = beat) with in_k=k SHALL leave out0..out15 = 0..15 after 16 beats.
REQ-040 With HALFWORD_SERIALIZER_LAST_EN defined, out_last SHALL pulse only with out_data=in0, including during stalls on the final beat.
